// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: drives a req/ack instruction-memory port and returns
// fetched words tagged with their PC, honouring stall, branch and flush redirects.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_OFF   | chip disabled, PC parked at RESET_VECTOR, no request
// ST_FETCH | imem_req asserted at program_counter until imem_ack
// ST_HOLD  | pipeline stalled, no request, PC frozen (redirects still apply)
module pc_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    STALL_WIDTH  = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [STALL_WIDTH-1:0]  stop_all,
    input  logic                    is_branch_input,
    input  logic [ADDR_WIDTH-1:0]   branch_address_input,
    input  logic                    flush_input,
    input  logic [ADDR_WIDTH-1:0]   flush_address_input,
    output logic                    imem_req,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic                    imem_ack,
    input  logic [DATA_WIDTH-1:0]   imem_data,
    output logic [ADDR_WIDTH-1:0]   program_counter,
    output logic                    chip_enable,
    output logic                    inst_valid,
    output logic [DATA_WIDTH-1:0]   inst_data,
    output logic [ADDR_WIDTH-1:0]   inst_pc,
    output logic                    addr_misaligned
);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic                  chip_enable_q;
    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_flush_q, pend_flush_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  stall_pend_q, stall_pend_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [DATA_WIDTH-1:0] inst_data_q, inst_data_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  misaligned_q, misaligned_d;

    logic                  sel_valid, sel_flush;
    logic [ADDR_WIDTH-1:0] sel_addr, new_addr;
    logic                  stall_now;
    logic                  unused_stall_bits;

    assign unused_stall_bits = ^stop_all[STALL_WIDTH-1:1];

    // Merge a fresh redirect with the pending one: flush beats branch, a newer flush
    // replaces an older one, but a branch never displaces a pending flush.
    always_comb begin
        sel_valid = 1'b0;
        sel_flush = 1'b0;
        sel_addr  = '0;
        if (flush_input) begin
            sel_valid = 1'b1;
            sel_flush = 1'b1;
            sel_addr  = flush_address_input;
        end else if (pend_valid_q && pend_flush_q) begin
            sel_valid = 1'b1;
            sel_flush = 1'b1;
            sel_addr  = pend_addr_q;
        end else if (is_branch_input) begin
            sel_valid = 1'b1;
            sel_addr  = branch_address_input;
        end else if (pend_valid_q) begin
            sel_valid = 1'b1;
            sel_addr  = pend_addr_q;
        end
    end

    assign new_addr  = flush_input ? flush_address_input : branch_address_input;
    assign stall_now = stop_all[0] | stall_pend_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_flush_d = pend_flush_q;
        pend_addr_d  = pend_addr_q;
        stall_pend_d = stall_pend_q;
        inst_valid_d = 1'b0;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        misaligned_d = 1'b0;

        case (state_q)
            ST_OFF: begin
                pc_d = RESET_VECTOR;
                if (chip_enable_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    pend_valid_d = 1'b0;
                    pend_flush_d = 1'b0;
                    stall_pend_d = 1'b0;
                    if (sel_valid) begin
                        pc_d         = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                        misaligned_d = |sel_addr[1:0];
                    end else begin
                        inst_valid_d = 1'b1;
                        inst_data_d  = imem_data;
                        inst_pc_d    = pc_q;
                        pc_d         = pc_q + ADDR_WIDTH'(4);
                    end
                    state_d = stall_now ? ST_HOLD : ST_FETCH;
                end else begin
                    // Request must stay stable; park redirect and stall until the ack.
                    pend_valid_d = sel_valid;
                    pend_flush_d = sel_flush;
                    pend_addr_d  = sel_addr;
                    stall_pend_d = stall_now;
                end
            end
            ST_HOLD: begin
                if (flush_input || is_branch_input) begin
                    pc_d         = {new_addr[ADDR_WIDTH-1:2], 2'b00};
                    misaligned_d = |new_addr[1:0];
                end
                state_d = stop_all[0] ? ST_HOLD : ST_FETCH;
            end
            default: state_d = ST_OFF;
        endcase

        if (!chip_enable_q) begin
            state_d      = ST_OFF;
            pc_d         = RESET_VECTOR;
            pend_valid_d = 1'b0;
            pend_flush_d = 1'b0;
            stall_pend_d = 1'b0;
            inst_valid_d = 1'b0;
            misaligned_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            chip_enable_q <= 1'b0;
            state_q       <= ST_OFF;
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_flush_q  <= 1'b0;
            pend_addr_q   <= '0;
            stall_pend_q  <= 1'b0;
            inst_valid_q  <= 1'b0;
            inst_data_q   <= '0;
            inst_pc_q     <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            chip_enable_q <= 1'b1;
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_flush_q  <= pend_flush_d;
            pend_addr_q   <= pend_addr_d;
            stall_pend_q  <= stall_pend_d;
            inst_valid_q  <= inst_valid_d;
            inst_data_q   <= inst_data_d;
            inst_pc_q     <= inst_pc_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign imem_req        = (state_q == ST_FETCH);
    assign imem_addr       = pc_q;
    assign program_counter = pc_q;
    assign chip_enable     = chip_enable_q;
    assign inst_valid      = inst_valid_q;
    assign inst_data       = inst_data_q;
    assign inst_pc         = inst_pc_q;
    assign addr_misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: memory returns ~address as the instruction word,
// so each delivered word can be checked against its hand-computed PC.
module tb_pc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  stop_all;
    logic        is_branch_input;
    logic [31:0] branch_address_input;
    logic        flush_input;
    logic [31:0] flush_address_input;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] program_counter;
    logic        chip_enable;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        addr_misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit dut (
        .clock                (clock),
        .reset                (reset),
        .stop_all             (stop_all),
        .is_branch_input      (is_branch_input),
        .branch_address_input (branch_address_input),
        .flush_input          (flush_input),
        .flush_address_input  (flush_address_input),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ack             (imem_ack),
        .imem_data            (imem_data),
        .program_counter      (program_counter),
        .chip_enable          (chip_enable),
        .inst_valid           (inst_valid),
        .inst_data            (inst_data),
        .inst_pc              (inst_pc),
        .addr_misaligned      (addr_misaligned)
    );

    always #5 clock = ~clock;
    assign imem_data = ~imem_addr;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stop_all = '0; is_branch_input = 1'b0; branch_address_input = '0;
        flush_input = 1'b0; flush_address_input = '0; imem_ack = 1'b0;
        step(); step(); step();
        chk("rst_ce", 32'(chip_enable), 32'd0);
        chk("rst_pc", program_counter, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_iv", 32'(inst_valid), 32'd0);
        chk("rst_idata", inst_data, 32'h0);
        chk("rst_ipc", inst_pc, 32'h0);
        chk("rst_mis", 32'(addr_misaligned), 32'd0);

        // release, ack tied high: one word per cycle
        reset = 1'b0; imem_ack = 1'b1;
        step();
        chk("en_ce", 32'(chip_enable), 32'd1);
        chk("en_req_off", 32'(imem_req), 32'd0);
        step();
        chk("f_req", 32'(imem_req), 32'd1);
        chk("f_addr0", imem_addr, 32'h0);
        step();
        chk("f_iv0", 32'(inst_valid), 32'd1);
        chk("f_ipc0", inst_pc, 32'h0);
        chk("f_data0", inst_data, ~32'h0);
        chk("f_pc4", program_counter, 32'h4);
        step();
        chk("f_iv4", 32'(inst_valid), 32'd1);
        chk("f_ipc4", inst_pc, 32'h4);
        chk("f_pc8", program_counter, 32'h8);

        // delayed ack at 0x8 with a stall pulse during the wait
        imem_ack = 1'b0;
        step();
        chk("w_iv", 32'(inst_valid), 32'd0);
        chk("w_addr_a", imem_addr, 32'h8);
        stop_all[0] = 1'b1;
        step();
        chk("w_req_b", 32'(imem_req), 32'd1);
        chk("w_addr_b", imem_addr, 32'h8);
        stop_all[0] = 1'b0;
        step();
        chk("w_addr_c", imem_addr, 32'h8);
        imem_ack = 1'b1;
        step();
        chk("w_iv8", 32'(inst_valid), 32'd1);
        chk("w_ipc8", inst_pc, 32'h8);
        chk("w_data8", inst_data, ~32'h8);
        chk("h_pcC", program_counter, 32'hC);
        chk("h_req", 32'(imem_req), 32'd0);
        stop_all[0] = 1'b1;
        step();
        chk("h_req2", 32'(imem_req), 32'd0);
        chk("h_pc2", program_counter, 32'hC);
        chk("h_iv", 32'(inst_valid), 32'd0);
        stop_all[0] = 1'b0;
        step();
        chk("h_exit_req", 32'(imem_req), 32'd1);
        chk("h_exit_addr", imem_addr, 32'hC);
        step();
        chk("f_ipcC", inst_pc, 32'hC);
        chk("f_pc10", program_counter, 32'h10);

        // branch while 0x10 outstanding, ack two cycles later
        imem_ack = 1'b0; is_branch_input = 1'b1; branch_address_input = 32'h100;
        step();
        chk("b_addr_hold", imem_addr, 32'h10);
        is_branch_input = 1'b0;
        step();
        chk("b_addr_hold2", imem_addr, 32'h10);
        imem_ack = 1'b1;
        step();
        chk("b_discard", 32'(inst_valid), 32'd0);
        chk("b_addr100", imem_addr, 32'h100);

        // flush + branch same cycle, then a branch in the pending window
        imem_ack = 1'b0;
        flush_input = 1'b1; flush_address_input = 32'h180;
        is_branch_input = 1'b1; branch_address_input = 32'h200;
        step();
        chk("fl_addr_hold", imem_addr, 32'h100);
        flush_input = 1'b0; branch_address_input = 32'h300;
        step();
        chk("fl_iv", 32'(inst_valid), 32'd0);
        is_branch_input = 1'b0; imem_ack = 1'b1;
        step();
        chk("fl_pc180", program_counter, 32'h180);
        chk("fl_discard", 32'(inst_valid), 32'd0);

        // misaligned branch coinciding with an ack
        is_branch_input = 1'b1; branch_address_input = 32'h203;
        step();
        chk("m_pc200", program_counter, 32'h200);
        chk("m_pulse", 32'(addr_misaligned), 32'd1);
        chk("m_discard", 32'(inst_valid), 32'd0);
        is_branch_input = 1'b0;
        step();
        chk("m_pulse_end", 32'(addr_misaligned), 32'd0);
        chk("m_ipc200", inst_pc, 32'h200);
        chk("m_pc204", program_counter, 32'h204);

        // wrap at the top of the address space
        is_branch_input = 1'b1; branch_address_input = 32'hFFFF_FFFC;
        step();
        chk("wr_pc", program_counter, 32'hFFFF_FFFC);
        chk("wr_nomis", 32'(addr_misaligned), 32'd0);
        is_branch_input = 1'b0;
        step();
        chk("wr_ipc", inst_pc, 32'hFFFF_FFFC);
        chk("wr_pc0", program_counter, 32'h0);

        // flush overrides a stall in HOLD; stall keeps holding at the new PC
        stop_all[0] = 1'b1;
        step();
        chk("hf_ipc0", inst_pc, 32'h0);
        chk("hf_pc4", program_counter, 32'h4);
        chk("hf_req", 32'(imem_req), 32'd0);
        flush_input = 1'b1; flush_address_input = 32'h41;
        step();
        chk("hf_pc40", program_counter, 32'h40);
        chk("hf_mis", 32'(addr_misaligned), 32'd1);
        chk("hf_req2", 32'(imem_req), 32'd0);
        flush_input = 1'b0; stop_all[0] = 1'b0;
        step();
        chk("hf_resume", 32'(imem_req), 32'd1);
        chk("hf_addr40", imem_addr, 32'h40);

        // reset with a request outstanding, then a late ack
        imem_ack = 1'b0;
        step();
        chk("rs_out_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        step();
        chk("rs_req0", 32'(imem_req), 32'd0);
        chk("rs_pc", program_counter, 32'h0);
        chk("rs_ce", 32'(chip_enable), 32'd0);
        reset = 1'b0; imem_ack = 1'b1;
        step();
        chk("rs_late_iv", 32'(inst_valid), 32'd0);
        chk("rs_late_req", 32'(imem_req), 32'd0);
        step();
        chk("rs_iv2", 32'(inst_valid), 32'd0);
        chk("rs_refetch", 32'(imem_req), 32'd1);
        chk("rs_addr0", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the basic program-counter register.
- Generates the fetch address, drives a req/ack handshake to instruction memory and returns the fetched word tagged with its PC.
- Supports pipeline stall, branch redirect and exception flush with priority, including redirects that arrive while a fetch is outstanding.
- Sits between the IF/ID pipeline register and the instruction memory port.

Parameters:
ADDR_WIDTH, 32, width of PC and instruction address
DATA_WIDTH, 32, instruction word width
RESET_VECTOR, 32'h00000000, PC value while chip disabled
STALL_WIDTH, 6, width of pipeline stall vector; bit 0 stalls fetch

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
stop_all  input  STALL_WIDTH  stall vector; only bit 0 used here
is_branch_input  input  1  branch redirect request from ID
branch_address_input  input  ADDR_WIDTH  branch target
flush_input  input  1  exception flush request
flush_address_input  input  ADDR_WIDTH  exception handler address
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_WIDTH  fetch address (equals program_counter)
imem_ack  input  1  memory accepted request, data valid this cycle
imem_data  input  DATA_WIDTH  instruction word, valid with imem_ack
program_counter  output  ADDR_WIDTH  current fetch PC
chip_enable  output  1  registered enable
inst_valid  output  1  inst_data/inst_pc valid (one-cycle pulse)
inst_data  output  DATA_WIDTH  fetched instruction
inst_pc  output  ADDR_WIDTH  PC of inst_data
addr_misaligned  output  1  one-cycle pulse: redirect target had bits [1:0] != 0

Behaviour:
- chip_enable <= !reset each clock. While chip_enable=0: program_counter=RESET_VECTOR, state OFF, pending cleared, all pulses 0.
- Reset values: chip_enable=0, program_counter=RESET_VECTOR, imem_req=0, inst_valid=0, inst_data=0, inst_pc=0, addr_misaligned=0.
- States:
  - OFF: exits to FETCH on the first cycle chip_enable=1.
  - FETCH: imem_req=1.
  - HOLD: imem_req=0 while stop_all[0]=1.
- FETCH, no stall, no redirect: each cycle with imem_req and imem_ack=1:
  - next cycle inst_valid=1, inst_data=imem_data, inst_pc=old PC; PC += 4.
  - Back-to-back acks give one instruction per cycle.
- Request stability: once imem_req=1 without ack, imem_req and imem_addr hold until ack, regardless of stall or redirect.
- Stall: stop_all[0]=1 with no outstanding request enters HOLD and PC is frozen. If the stall arrives while a request is outstanding, it takes effect the cycle after the ack. The acked word is still delivered and PC still advances.
- Redirect priority: flush > branch > stall > increment.
  - Redirect with no outstanding request: PC <= target next cycle. Applies even in HOLD (flush and branch override stall). The stall then continues holding at the new PC.
  - Redirect during an outstanding request: target latched into a pending register; a later flush overwrites a pending branch, a later branch never overwrites a pending flush. On ack the word is discarded (inst_valid stays 0) and PC <= pending target.
  - Redirect in the same cycle as ack: handled as a pending redirect resolving that cycle. The word is discarded.
- Targets: bits [1:0] forced to 0 when loaded into PC. addr_misaligned pulses for 1 cycle if the original bits were nonzero.
- PC increment wraps modulo 2^ADDR_WIDTH (all-ones-minus-3 -> 0).
- Reset mid-fetch: imem_req drops the next cycle, the outstanding ack is ignored and the pending register is cleared.

Test Plan:
- Reset 3 cycles, release, imem_ack tied 1 -> chip_enable=1 one cycle after release; inst_pc sequence 0,4,8,C; inst_valid continuous.
- imem_ack delayed 3 cycles at PC=0x8 with stop_all[0] pulsed mid-wait -> imem_addr held 0x8, word delivered with inst_pc=0x8, then HOLD with PC=0xC until stall clears.
- Branch to 0x100 while request at 0x10 outstanding, ack 2 cycles later -> no inst_valid for 0x10; next imem_addr=0x100.
- Flush to 0x180 and branch to 0x200 in the same cycle, then a branch during the pending window -> PC=0x180; branch ignored.
- Branch target 0x203 -> PC=0x200, addr_misaligned one-cycle pulse; PC=0xFFFFFFFC acked -> PC wraps to 0x0.
- Reset asserted with request outstanding -> imem_req=0 the next cycle, PC=RESET_VECTOR; a late ack produces no inst_valid.
